// File: rtl/sparse_hdc_pkg.sv
// Shared constants, clear-FSM encoding and default level hypervector for the sparse HDC encoder.
package sparse_hdc_pkg;

  localparam int NUM_LEVELS_D = 10;
  localparam int LVL_W_D      = 4;
  localparam int HV_W_D       = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } im_state_e;

  // Default entry: top hypervector bit set, level index in the low bits.
  function automatic logic [31:0] default_level_hv(input int unsigned i, input int unsigned hv_w);
    logic [31:0] hv;
    hv = (32'd1 << (hv_w - 1)) | 32'(i);
    return hv;
  endfunction

endpackage

// File: rtl/im_storage.sv
// Item-memory register array: async-reset default load, one write port, write-first combinational read.
// IM_PARITY_EN adds a stored even-parity bit per entry and a read-side parity check.
module im_storage
  import sparse_hdc_pkg::*;
#(
  parameter int NUM_LEVELS = NUM_LEVELS_D,
  parameter int LVL_W      = LVL_W_D,
  parameter int HV_W       = HV_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [LVL_W-1:0] wr_addr,
  input  logic [HV_W-1:0]  wr_data,
  input  logic [LVL_W-1:0] rd_addr,
`ifdef IM_PARITY_EN
  output logic             rd_perr,
`endif
  output logic [HV_W-1:0]  rd_data
);

`ifdef IM_PARITY_EN
  localparam int ENT_W = HV_W + 1;
`else
  localparam int ENT_W = HV_W;
`endif

  logic [ENT_W-1:0] mem [NUM_LEVELS];
  logic [ENT_W-1:0] wr_ent;
  logic [ENT_W-1:0] rd_ent;

  function automatic logic [ENT_W-1:0] encode(input logic [HV_W-1:0] d);
`ifdef IM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign wr_ent = encode(wr_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        mem[i] <= encode(HV_W'(default_level_hv(i, HV_W)));
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_ent;
    end
  end

  // A same-cycle write to the read address bypasses the array so the reader sees the new value.
  always_comb begin
    rd_ent = '0;
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_ent = wr_ent;
    end else if ({1'b0, rd_addr} < (LVL_W+1)'(NUM_LEVELS)) begin
      rd_ent = mem[rd_addr];
    end
  end

  assign rd_data = rd_ent[HV_W-1:0];

`ifdef IM_PARITY_EN
  assign rd_perr = ^rd_ent;
`endif

endmodule

// File: rtl/im_fetch_pipe.sv
// Pipelined level item memory: level index in, registered level hypervector out, with a clear sweep.
// Optional IM_PARITY_EN adds per-entry parity and the out_perr output.
module im_fetch_pipe
  import sparse_hdc_pkg::*;
#(
  parameter int NUM_LEVELS = NUM_LEVELS_D,
  parameter int LVL_W      = LVL_W_D,
  parameter int HV_W       = HV_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LVL_W-1:0] in_level,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HV_W-1:0]  out_hv,
  output logic             out_oor,
`ifdef IM_PARITY_EN
  output logic             out_perr,
`endif
  input  logic             wr_en,
  input  logic [LVL_W-1:0] wr_addr,
  input  logic [HV_W-1:0]  wr_data,
  input  logic             clr_start,
  output logic             busy
);

  localparam logic [LVL_W:0]   LEVELS_EXT = (LVL_W+1)'(NUM_LEVELS);
  localparam logic [LVL_W-1:0] LAST_IDX   = LVL_W'(NUM_LEVELS - 1);

  im_state_e        state_q, state_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             in_oor;
  logic             user_wr;
  logic             mem_we;
  logic [LVL_W-1:0] mem_waddr;
  logic [HV_W-1:0]  mem_wdata;
  logic [HV_W-1:0]  rd_hv;
`ifdef IM_PARITY_EN
  logic             rd_perr;
`endif

  assign busy     = (state_q == CLEAR);
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign in_oor   = ({1'b0, in_level} >= LEVELS_EXT);
  assign user_wr  = wr_en && !busy && ({1'b0, wr_addr} < LEVELS_EXT);

  // The sweep owns the write port while busy, so user writes are dropped then.
  always_comb begin
    mem_we    = user_wr;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end
  end

  im_storage #(
    .NUM_LEVELS(NUM_LEVELS),
    .LVL_W     (LVL_W),
    .HV_W      (HV_W)
  ) u_storage (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (mem_we),
    .wr_addr(mem_waddr),
    .wr_data(mem_wdata),
    .rd_addr(in_level),
`ifdef IM_PARITY_EN
    .rd_perr(rd_perr),
`endif
    .rd_data(rd_hv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: loads on accept (also covers pop+accept), empties on a bare pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hv    <= '0;
      out_oor   <= 1'b0;
`ifdef IM_PARITY_EN
      out_perr  <= 1'b0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_hv    <= in_oor ? '0 : rd_hv;
      out_oor   <= in_oor;
`ifdef IM_PARITY_EN
      out_perr  <= in_oor ? 1'b0 : rd_perr;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_im_fetch_pipe.sv
// Scoreboard bench for im_fetch_pipe against a table-level reference model.
// Build with IM_PARITY_EN defined to also exercise out_perr.
module tb_im_fetch_pipe;

  localparam int NL = 10;
  localparam int LW = 4;
  localparam int HW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_level = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [HW-1:0] out_hv;
  logic          out_oor;
`ifdef IM_PARITY_EN
  logic          out_perr;
`endif
  logic          wr_en = 1'b0;
  logic [LW-1:0] wr_addr = '0;
  logic [HW-1:0] wr_data = '0;
  logic          clr_start = 1'b0;
  logic          busy;

  typedef struct {
    logic [HW-1:0] hv;
    logic          oor;
    logic          perr;
  } exp_t;

  exp_t          sb[$];
  logic [HW-1:0] table_m [NL];
  int            busy_left = 0;
  bit            corrupt3 = 1'b0;
  int            errors = 0;
  int            checks = 0;

  im_fetch_pipe #(.NUM_LEVELS(NL), .LVL_W(LW), .HV_W(HW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_level (in_level),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hv   (out_hv),
    .out_oor  (out_oor),
`ifdef IM_PARITY_EN
    .out_perr (out_perr),
`endif
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_start(clr_start),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NL; i++) table_m[i] = HW'((1 << (HW - 1)) | i);
    sb.delete();
    busy_left = 0;
    corrupt3  = 1'b0;
  endtask

  // One clock cycle of stimulus; the model reacts to what the DUT should do at the coming edge.
  task automatic applyStimulus(input bit v, input int lvl, input bit rdy, input bit we,
                               input int wa, input logic [HW-1:0] wd, input bit clr);
    bit   exp_ready;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_level  = LW'(lvl);
    out_ready = rdy;
    wr_en     = we;
    wr_addr   = LW'(wa);
    wr_data   = wd;
    clr_start = clr;
    #3;
    checkOutput("busy", 32'(busy), 32'(busy_left > 0));
    exp_ready = (busy_left == 0) && (sb.size() == 0 || rdy);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    if (busy_left == 0 && we && wa < NL) begin
      table_m[wa] = wd;
      if (wa == 3) corrupt3 = 1'b0;
    end
    if (v && exp_ready) begin
      e.oor  = (lvl >= NL);
      e.hv   = e.oor ? '0 : table_m[lvl];
      e.perr = !e.oor && corrupt3 && (lvl == 3);
      sb.push_back(e);
    end
    if (busy_left > 0) begin
      busy_left--;
    end else if (clr) begin
      for (int i = 0; i < NL; i++) table_m[i] = '0;
      corrupt3  = 1'b0;
      busy_left = NL;
    end
  endtask

  task automatic drain();
    repeat (3) applyStimulus(0, 0, 1, 0, 0, '0, 0);
  endtask

  // Monitor: whenever a result is presented it must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", 32'(out_valid), 32'(0));
        end else begin
          checkOutput("out_hv", 32'(out_hv), 32'(sb[0].hv));
          checkOutput("out_oor", 32'(out_oor), 32'(sb[0].oor));
`ifdef IM_PARITY_EN
          checkOutput("out_perr", 32'(out_perr), 32'(sb[0].perr));
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_out_hv", 32'(out_hv), 32'(0));
    checkOutput("rst_out_oor", 32'(out_oor), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));

    $display("[TB] back-to-back default reads");
    applyStimulus(1, 0, 1, 0, 0, '0, 0);
    applyStimulus(1, 1, 1, 0, 0, '0, 0);
    applyStimulus(1, 9, 1, 0, 0, '0, 0);

    $display("[TB] out-of-range level and output stall");
    applyStimulus(1, 12, 1, 0, 0, '0, 0);
    repeat (3) applyStimulus(1, 3, 0, 0, 0, '0, 0);
    applyStimulus(1, 3, 1, 0, 0, '0, 0);
    drain();

    $display("[TB] write-first and ignored out-of-range write");
    applyStimulus(1, 4, 1, 1, 4, 10'h3FF, 0);
    applyStimulus(0, 0, 1, 1, 11, 10'h155, 0);
    for (int i = 0; i < NL; i++) applyStimulus(1, i, 1, 0, 0, '0, 0);
    drain();

    $display("[TB] clear sweep");
    applyStimulus(0, 0, 1, 0, 0, '0, 1);
    for (int i = 0; i < NL; i++) applyStimulus(1, i, 1, 1, i, 10'h2AA, i == 4);
    for (int i = 0; i < NL; i++) applyStimulus(1, i, 1, 0, 0, '0, 0);
    drain();

    $display("[TB] reset during sweep with pending output");
    applyStimulus(1, 5, 0, 0, 0, '0, 1);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, '0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NL; i++) applyStimulus(1, i, 1, 0, 0, '0, 0);
    drain();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 15)), HW'($urandom), $urandom_range(0, 49) == 0);
    end
    repeat (NL) applyStimulus(0, 0, 1, 0, 0, '0, 0);
    drain();

`ifdef IM_PARITY_EN
    $display("[TB] parity error injection");
    applyStimulus(0, 0, 1, 1, 3, 10'h0F0, 0);
    @(negedge clk);
    force dut.u_storage.mem[3] = {^table_m[3], table_m[3] ^ HW'(1)};
    table_m[3] = table_m[3] ^ HW'(1);
    corrupt3   = 1'b1;
    applyStimulus(1, 3, 1, 0, 0, '0, 0);
    applyStimulus(1, 2, 1, 0, 0, '0, 0);
    drain();
    release dut.u_storage.mem[3];
    applyStimulus(1, 3, 1, 1, 3, 10'h111, 0);
    drain();
`endif

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
